ctrl_hazard: RTL

CTRL_HAZARD -- requirements
Module: ctrl_hazard

---
 rtl/ctrl_hazard_pkg.sv | 41 ++++
 rtl/ctrl_hazard_dff.sv | 24 ++
 rtl/ctrl_hazard.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ctrl_hazard_pkg.sv
// ctrl_hazard_pkg: shared bus-width defines, FSM state encodings and
// constants for the pipeline hazard controller.
// Optional feature macro: CTRL_STALL_TIMEOUT_EN (stall-timeout watchdog).

`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef CTRL_RUN
`define CTRL_RUN 2'b00
`endif
`ifndef CTRL_STALL
`define CTRL_STALL 2'b01
`endif
`ifndef CTRL_JPEND
`define CTRL_JPEND 2'b10
`endif

package ctrl_hazard_pkg;

  // Controller states: normal flow, frozen pipeline, frozen with a jump waiting
  typedef enum logic [1:0] {
    ST_RUN   = `CTRL_RUN,
    ST_STALL = `CTRL_STALL,
    ST_JPEND = `CTRL_JPEND
  } ctrl_state_t;

  localparam int ADDR_W = 32;

  // Saturation value of the consecutive-stall counter
  localparam logic [7:0] STALL_CNT_MAX = 8'hFF;

endpackage

// File: rtl/ctrl_hazard_dff.sv
// ctrl_hazard_dff: shared load-enabled register cell with asynchronous
// active-low reset to a fixed value.

module ctrl_hazard_dff #(
  parameter int         W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled, otherwise hold; reset restores RST_VAL
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_hazard.sv
// ctrl_hazard: pipeline hazard controller. Freezes pc/if_id/id_ex while the
// bus or the divider stalls, redirects the pc on taken jumps, and defers a
// jump that arrives during a stall until the stall clears.
// Optional feature macro: CTRL_STALL_TIMEOUT_EN adds a sticky watchdog that
// flags STALL_LIMIT consecutive stall cycles; without it stall_timeout_o is 0.

module ctrl_hazard
  import ctrl_hazard_pkg::*;
#(
  parameter logic [7:0] STALL_LIMIT = 8'd200
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           jump_flag_i,
  input  logic [`RegBus] jump_addr_i,
  input  logic           div_busy_i,
  input  logic           bus_stall_i,
  output logic           jump_flag_o,
  output logic [`RegBus] jump_addr_o,
  output logic           hold_pc_o,
  output logic           hold_if_id_o,
  output logic           hold_id_ex_o,
  output logic           flush_if_id_o,
  output logic           flush_id_ex_o,
  output logic           stall_timeout_o
);

  ctrl_state_t    state;
  logic           stall;
  logic           pend_load;
  logic [`RegBus] pend_addr;

  assign stall     = bus_stall_i | div_busy_i;
  assign pend_load = stall & jump_flag_i;

  // Pending jump target; the newest jump seen during a stall wins
  ctrl_hazard_dff #(
    .W       (ADDR_W),
    .RST_VAL (`ZeroWord)
  ) u_pend_addr (
    .clk  (clk),
    .rstn (rstn),
    .en   (pend_load),
    .d    (jump_addr_i),
    .q    (pend_addr)
  );

  // State sequencing: stall dominates, a jump under stall becomes pending
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (stall) begin
            state <= jump_flag_i ? ST_JPEND : ST_STALL;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_JPEND: begin
          state <= stall ? ST_JPEND : ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Same-cycle hold/flush/redirect decode; everything is quiet during reset
  always_comb begin
    jump_flag_o   = `Disable;
    jump_addr_o   = `ZeroWord;
    hold_pc_o     = `Disable;
    hold_if_id_o  = `Disable;
    hold_id_ex_o  = `Disable;
    flush_if_id_o = `Disable;
    flush_id_ex_o = `Disable;
    if (rstn) begin
      if (stall) begin
        hold_pc_o    = `Enable;
        hold_if_id_o = `Enable;
        hold_id_ex_o = `Enable;
      end else if (state == ST_JPEND) begin
        jump_flag_o   = `Enable;
        jump_addr_o   = pend_addr;
        flush_if_id_o = `Enable;
        flush_id_ex_o = `Enable;
      end else if (jump_flag_i) begin
        jump_flag_o   = `Enable;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = `Enable;
        flush_id_ex_o = `Enable;
      end
    end
  end

`ifdef CTRL_STALL_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       timeout_q;

  // Count consecutive stall cycles, saturating; any free cycle clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= 8'd0;
    end else if (!stall) begin
      stall_cnt <= 8'd0;
    end else if (stall_cnt != STALL_CNT_MAX) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // Latch the timeout once the count hits the limit; only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_q <= 1'b0;
    end else if (stall_cnt == STALL_LIMIT) begin
      timeout_q <= 1'b1;
    end
  end

  assign stall_timeout_o = rstn & (timeout_q | (stall_cnt == STALL_LIMIT));
`else
  logic unused_limit;

  assign unused_limit    = ^STALL_LIMIT;
  assign stall_timeout_o = `Disable;
`endif

endmodule
